// File: rtl/text_console_if.sv
// Byte-stream input and char-buffer write port of the text console.
// Geometry parameters must match the controller instance.
interface text_console_if #(
  parameter int CHAR_ROWS = 12,
  parameter int CHAR_COLS = 8
);
  localparam int TEXT_ROWS = 480 / CHAR_ROWS;
  localparam int TEXT_COLS = 640 / CHAR_COLS;
  localparam int CELLS     = TEXT_ROWS * TEXT_COLS;
  localparam int ADDR_W    = $clog2(CELLS);
  localparam int COL_W     = $clog2(TEXT_COLS);
  localparam int ROW_W     = $clog2(TEXT_ROWS);

  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_data;
  logic              buf_write_en;
  logic [ADDR_W-1:0] buf_addr;
  logic [6:0]        buf_data;
  logic [COL_W-1:0]  cursor_col;
  logic [ROW_W-1:0]  cursor_row;
  logic              busy;

  modport master (
    output in_valid, in_data,
    input  in_ready, buf_write_en, buf_addr, buf_data,
    input  cursor_col, cursor_row, busy
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, buf_write_en, buf_addr, buf_data,
    output cursor_col, cursor_row, busy
  );
endinterface

// File: rtl/text_console_ctrl.sv
// Text console: byte stream -> char buffer writes, cursor, LF/CR/BS/FF.
// Define TEXT_CONSOLE_TAB_EN to make 0x09 advance to the next 8-col stop.
module text_console_ctrl #(
  parameter int CHAR_ROWS = 12,
  parameter int CHAR_COLS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  text_console_if.slave bus
);
  localparam int TEXT_ROWS = 480 / CHAR_ROWS;
  localparam int TEXT_COLS = 640 / CHAR_COLS;
  localparam int CELLS     = TEXT_ROWS * TEXT_COLS;
  localparam int ADDR_W    = $clog2(CELLS);
  localparam int COL_W     = $clog2(TEXT_COLS);
  localparam int ROW_W     = $clog2(TEXT_ROWS);

  typedef enum logic {CLEAR, IDLE} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [6:0]        data_q, data_d;
  logic              ff_d;

  logic [7:0]        d;
  logic              accept;
  logic              is_print, is_lf, is_cr, is_bs, is_ff;
  logic              col_last;
  logic [ROW_W-1:0]  row_inc;
  logic [ADDR_W-1:0] cur_addr;

  assign d        = bus.in_data;
  assign accept   = bus.in_valid && (state_q == IDLE);
  assign is_print = (d >= 8'h20) && (d <= 8'h7E);
  assign is_lf    = (d == 8'h0A);
  assign is_cr    = (d == 8'h0D);
  assign is_bs    = (d == 8'h08);
  assign is_ff    = (d == 8'h0C);
  assign col_last = (col_q == COL_W'(TEXT_COLS - 1));
  // No scrolling: the line after the last row is row 0.
  assign row_inc  = (row_q == ROW_W'(TEXT_ROWS - 1)) ?
                    '0 : row_q + 1'b1;
  assign cur_addr = ADDR_W'(row_q) * ADDR_W'(TEXT_COLS)
                  + ADDR_W'(col_q);

`ifdef TEXT_CONSOLE_TAB_EN
  logic             is_tab;
  logic [COL_W:0]   tab_sum;
  assign is_tab  = (d == 8'h09);
  assign tab_sum = ({1'b0, col_q} | (COL_W+1)'(7))
                 + (COL_W+1)'(1);
`endif

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    we_d   = 1'b0;
    addr_d = cur_addr;
    data_d = 7'h00;
    ff_d   = 1'b0;
    if (accept) begin
      unique case (1'b1)
        is_print: begin
          we_d   = 1'b1;
          data_d = d[6:0];
          if (col_last) begin
            col_d = '0;
            row_d = row_inc;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        is_lf: begin
          col_d = '0;
          row_d = row_inc;
        end
        is_cr: col_d = '0;
        is_bs: begin
          if (col_q != '0) begin
            col_d  = col_q - 1'b1;
            we_d   = 1'b1;
            addr_d = cur_addr - 1'b1;
          end
        end
        is_ff: begin
          col_d = '0;
          row_d = '0;
          ff_d  = 1'b1;
        end
`ifdef TEXT_CONSOLE_TAB_EN
        is_tab: begin
          if (tab_sum >= (COL_W+1)'(TEXT_COLS)) begin
            col_d = '0;
            row_d = row_inc;
          end else begin
            col_d = tab_sum[COL_W-1:0];
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      idx_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= 7'h00;
    end else begin
      unique case (state_q)
        CLEAR: begin
          we_q   <= 1'b1;
          addr_q <= idx_q;
          data_q <= 7'h00;
          if (idx_q == ADDR_W'(CELLS - 1)) begin
            idx_q   <= '0;
            state_q <= IDLE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        IDLE: begin
          we_q  <= we_d;
          col_q <= col_d;
          row_q <= row_d;
          if (we_d) begin
            addr_q <= addr_d;
            data_q <= data_d;
          end
          if (ff_d) begin
            idx_q   <= '0;
            state_q <= CLEAR;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.busy         = (state_q == CLEAR);
  assign bus.buf_write_en = we_q;
  assign bus.buf_addr     = addr_q;
  assign bus.buf_data     = data_q;
  assign bus.cursor_col   = col_q;
  assign bus.cursor_row   = row_q;
endmodule

// File: tb/tb_text_console_ctrl.sv
// Scoreboard bench for text_console_ctrl: expected writes are queued
// by the stimulus and popped by a negedge monitor on buf_write_en.
module tb_text_console_ctrl;
  localparam int CELLS = 3200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  text_console_if bus ();

  text_console_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  int exp_q[$];
  int last_addr = -1;
  int sweep_err = 0;
  int w;
  int c0;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic push(input int a, input int dat);
    exp_q.push_back(a * 128 + dat);
  endtask

  task automatic push_clear();
    for (int i = 0; i < CELLS; i++) push(i, 0);
  endtask

  always @(negedge clk) begin
    if (bus.buf_write_en) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got=%0d/%0h exp=none",
                 bus.buf_addr, bus.buf_data);
      end else begin
        int e;
        e = exp_q.pop_front();
        if ({bus.buf_addr, bus.buf_data} !== 19'(e)) begin
          bad++;
          $display("FAIL write got=%0d/%0h exp=%0d/%0h",
                   bus.buf_addr, bus.buf_data, e / 128, e % 128);
        end
      end
      last_addr = int'(bus.buf_addr);
    end
  end

  // Counts negedges spent with in_ready low; sweep must hold busy
  // high and the cursor at home the whole time.
  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.in_ready && n < 5000) begin
      if (!bus.busy || bus.cursor_col != 0 || bus.cursor_row != 0)
        sweep_err++;
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout got=0 exp=1");
    end
  endtask

  task automatic send(input logic [7:0] b, output int n);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    wait_ready(n);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic snd(input logic [7:0] b);
    int n;
    send(b, n);
  endtask

  task automatic put(input logic [7:0] b, input int a);
    push(a, int'(b[6:0]));
    snd(b);
  endtask

  task automatic cur(input string nm, input int c, input int r);
    chk({nm, "_col"}, int'(bus.cursor_col), c);
    chk({nm, "_row"}, int'(bus.cursor_row), r);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #12;
    chk("rst_we", int'(bus.buf_write_en), 0);
    chk("rst_addr", int'(bus.buf_addr), 0);
    chk("rst_data", int'(bus.buf_data), 0);
    chk("rst_busy", int'(bus.busy), 1);
    chk("rst_ready", int'(bus.in_ready), 0);
    cur("rst", 0, 0);

    // Release at a negedge: first write on the next posedge, last
    // write and in_ready both visible CELLS posedges later.
    push_clear();
    @(negedge clk);
    rst_n = 1'b1;
    sweep_err = 0;
    wait_ready(w);
    chk("boot_sweep_len", w, CELLS);
    chk("boot_sweep_err", sweep_err, 0);
    @(negedge clk);
    chk("boot_ready_after", int'(bus.in_ready), 1);
    chk("boot_busy_after", int'(bus.busy), 0);
    chk("boot_queue", exp_q.size(), 0);

    put(8'h48, 0);
    put(8'h69, 1);
    cur("hi", 2, 0);

    snd(8'h0D);
    for (int i = 0; i < 80; i++) put(8'h41, i);
    put(8'h42, 80);
    cur("wrap1", 1, 1);
    for (int i = 0; i < 38; i++) snd(8'h0A);
    cur("lf38", 0, 39);
    for (int i = 0; i < 79; i++) put(8'h43, 3120 + i);
    cur("row39", 79, 39);
    put(8'h44, 3199);
    cur("wrap_top", 0, 0);

    for (int i = 0; i < 3; i++) snd(8'h0A);
    for (int i = 0; i < 5; i++) put(8'h61 + 8'(i), 240 + i);
    cur("pre_bs", 5, 3);
    push(244, 0);
    snd(8'h08);
    cur("bs", 4, 3);
    snd(8'h0D);
    cur("cr", 0, 3);
    snd(8'h08);
    cur("bs_col0", 0, 3);
    snd(8'h0A);
    cur("lf", 0, 4);
    snd(8'h01);
    snd(8'h7F);
    snd(8'hC1);
    cur("ignored", 0, 4);

    for (int i = 0; i < 3; i++) put(8'h65, 320 + i);
    snd(8'h09);
`ifdef TEXT_CONSOLE_TAB_EN
    c0 = 8;
`else
    c0 = 3;
`endif
    cur("tab1", c0, 4);
    for (int i = 0; i < 77 - c0; i++) put(8'h66, 320 + c0 + i);
    cur("pre_tab2", 77, 4);
    snd(8'h09);
`ifdef TEXT_CONSOLE_TAB_EN
    cur("tab2", 0, 5);
`else
    cur("tab2", 77, 4);
`endif

    push_clear();
    snd(8'h0C);
    chk("ff_ready_drop", int'(bus.in_ready), 0);
    push(0, 8'h58);
    sweep_err = 0;
    send(8'h58, w);
    chk("ff_sweep_len", w, CELLS);
    chk("ff_sweep_err", sweep_err, 0);
    cur("ff_x", 1, 0);

    push_clear();
    snd(8'h0C);
    w = 0;
    while (last_addr != 1000 && w < 2000) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("mid_reached_1000", last_addr, 1000);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", int'(bus.buf_write_en), 0);
    chk("mid_rst_addr", int'(bus.buf_addr), 0);
    chk("mid_rst_pending", exp_q.size(), CELLS - 1001);
    exp_q.delete();
    push_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sweep_err = 0;
    wait_ready(w);
    chk("restart_sweep_len", w, CELLS);
    chk("restart_sweep_err", sweep_err, 0);
    put(8'h5A, 0);
    cur("after_restart", 1, 0);

    repeat (4) @(negedge clk);
    chk("final_queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
